// File: rtl/ad9945_serial_rx.sv
// ad9945_serial_rx
//   Receive side of the AD9945 3-wire continuous serial write (SL, SCK, SDATA).
//   The pins are oversampled in sys_clk. A frame is a 3-bit start address
//   (A0 first) followed by consecutive 12-bit words (D0 first). The address
//   auto-increments per word. The four AFE registers are held here.
//   Optional build macro: AD9945_RX_SHADOW_EN. When it is defined, words land in
//   shadow registers and are committed only when a frame ends cleanly. A
//   malformed frame is dropped atomically.
module ad9945_serial_rx #(
   parameter int unsigned SYNC_STAGES = 2,
   parameter logic [7:0]  CLAMP_RST   = 8'd128
) (
   input  logic        sys_clk,
   input  logic        rst_n,
   input  logic        SL,
   input  logic        SCK,
   input  logic        SDATA,
   output logic [6:0]  oper,
   output logic [6:0]  ctrl,
   output logic [7:0]  clamp,
   output logic [9:0]  vga_gain,
   output logic        wr_stb,
   output logic [2:0]  wr_addr,
   output logic [11:0] wr_data,
   output logic        frame_done,
   output logic        frame_err
);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_ADDR,
      ST_DATA
   } state_e;

   // ------------------------------------------------------------------
   // Pin synchronizers and edge detection
   // ------------------------------------------------------------------
   logic [SYNC_STAGES-1:0] sl_sync_q;
   logic [SYNC_STAGES-1:0] sck_sync_q;
   logic [SYNC_STAGES-1:0] sd_sync_q;
   logic                   sl_s;
   logic                   sck_s;
   logic                   sd_s;
   logic                   sl_prev_q;
   logic                   sck_prev_q;
   logic                   sl_rise_q;
   logic                   sl_fall_q;
   logic                   sck_rise_q;
   logic                   sd_q;

   assign sl_s  = sl_sync_q[SYNC_STAGES-1];
   assign sck_s = sck_sync_q[SYNC_STAGES-1];
   assign sd_s  = sd_sync_q[SYNC_STAGES-1];

   // Synchronizer chains. They reset low, so an SL pin that is already low
   // when reset is released does not look like a frame start. A fresh high
   // then low sequence on SL is needed before a frame starts.
   always_ff @(posedge sys_clk or negedge rst_n) begin
      if (!rst_n) begin
         sl_sync_q  <= '0;
         sck_sync_q <= '0;
         sd_sync_q  <= '0;
      end else begin
         sl_sync_q  <= {sl_sync_q[SYNC_STAGES-2:0], SL};
         sck_sync_q <= {sck_sync_q[SYNC_STAGES-2:0], SCK};
         sd_sync_q  <= {sd_sync_q[SYNC_STAGES-2:0], SDATA};
      end
   end

   // Registered edge flags. SDATA is delayed alongside them so the data bit
   // lines up with its SCK rising edge.
   always_ff @(posedge sys_clk or negedge rst_n) begin
      if (!rst_n) begin
         sl_prev_q  <= 1'b0;
         sck_prev_q <= 1'b0;
         sl_rise_q  <= 1'b0;
         sl_fall_q  <= 1'b0;
         sck_rise_q <= 1'b0;
         sd_q       <= 1'b0;
      end else begin
         sl_prev_q  <= sl_s;
         sck_prev_q <= sck_s;
         sl_rise_q  <= sl_s & ~sl_prev_q;
         sl_fall_q  <= ~sl_s & sl_prev_q;
         sck_rise_q <= sck_s & ~sck_prev_q;
         sd_q       <= sd_s;
      end
   end

   // ------------------------------------------------------------------
   // Frame decoder FSM
   // ------------------------------------------------------------------
   state_e      state_q, state_d;
   logic [3:0]  bit_cnt_q, bit_cnt_d;
   logic [2:0]  addr_q, addr_d;
   logic [11:0] word_q, word_d;
   logic        seen_q, seen_d;
   logic        wr_stb_q, wr_stb_d;
   logic [2:0]  wr_addr_q, wr_addr_d;
   logic [11:0] wr_data_q, wr_data_d;
   logic        done_q, done_d;
   logic        err_q, err_d;
   logic [11:0] word_set;
   logic [2:0]  addr_set;

   // State register and the write/frame strobes.
   always_ff @(posedge sys_clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= ST_IDLE;
         bit_cnt_q <= '0;
         addr_q    <= '0;
         word_q    <= '0;
         seen_q    <= 1'b0;
         wr_stb_q  <= 1'b0;
         wr_addr_q <= '0;
         wr_data_q <= '0;
         done_q    <= 1'b0;
         err_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         bit_cnt_q <= bit_cnt_d;
         addr_q    <= addr_d;
         word_q    <= word_d;
         seen_q    <= seen_d;
         wr_stb_q  <= wr_stb_d;
         wr_addr_q <= wr_addr_d;
         wr_data_q <= wr_data_d;
         done_q    <= done_d;
         err_q     <= err_d;
      end
   end

   // Next-state logic. A completing SCK bit is handled before an SL rise in the
   // same cycle. This lets a 12th bit that arrives with SL rising still count as
   // a whole word.
   always_comb begin
      state_d   = state_q;
      bit_cnt_d = bit_cnt_q;
      addr_d    = addr_q;
      word_d    = word_q;
      seen_d    = seen_q;
      wr_stb_d  = 1'b0;
      wr_addr_d = wr_addr_q;
      wr_data_d = wr_data_q;
      done_d    = 1'b0;
      err_d     = 1'b0;

      word_set  = word_q;
      word_set[bit_cnt_q] = sd_q;
      addr_set  = addr_q;
      addr_set[bit_cnt_q[1:0]] = sd_q;

      case (state_q)
         ST_IDLE: begin
            if (sl_fall_q) begin
               state_d   = ST_ADDR;
               bit_cnt_d = '0;
               addr_d    = '0;
               word_d    = '0;
               seen_d    = 1'b0;
            end
         end
         ST_ADDR: begin
            if (sl_rise_q) begin
               state_d = ST_IDLE;
               err_d   = 1'b1;
            end else if (sck_rise_q) begin
               addr_d = addr_set;
               if (bit_cnt_q == 4'd2) begin
                  state_d   = ST_DATA;
                  bit_cnt_d = '0;
               end else begin
                  bit_cnt_d = bit_cnt_q + 4'd1;
               end
            end
         end
         ST_DATA: begin
            if (sck_rise_q) begin
               if (bit_cnt_q == 4'd11) begin
                  wr_stb_d  = 1'b1;
                  wr_addr_d = addr_q;
                  wr_data_d = word_set;
                  addr_d    = addr_q + 3'd1;
                  word_d    = '0;
                  bit_cnt_d = '0;
                  seen_d    = 1'b1;
               end else begin
                  word_d    = word_set;
                  bit_cnt_d = bit_cnt_q + 4'd1;
               end
            end
            if (sl_rise_q) begin
               state_d = ST_IDLE;
               if ((bit_cnt_d == 4'd0) && seen_d) begin
                  done_d = 1'b1;
               end else begin
                  err_d = 1'b1;
               end
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // ------------------------------------------------------------------
   // AFE register file
   // ------------------------------------------------------------------
   logic [6:0] oper_q, oper_d;
   logic [6:0] ctrl_q, ctrl_d;
   logic [7:0] clamp_q, clamp_d;
   logic [9:0] gain_q, gain_d;

`ifdef AD9945_RX_SHADOW_EN
   logic [6:0] sh_oper_q, sh_oper_d;
   logic [6:0] sh_ctrl_q, sh_ctrl_d;
   logic [7:0] sh_clamp_q, sh_clamp_d;
   logic [9:0] sh_gain_q, sh_gain_d;

   // Shadow registers. They take every completed word, including one that
   // completes in the same cycle that the frame ends.
   always_ff @(posedge sys_clk or negedge rst_n) begin
      if (!rst_n) begin
         sh_oper_q  <= '0;
         sh_ctrl_q  <= '0;
         sh_clamp_q <= CLAMP_RST;
         sh_gain_q  <= '0;
      end else begin
         sh_oper_q  <= sh_oper_d;
         sh_ctrl_q  <= sh_ctrl_d;
         sh_clamp_q <= sh_clamp_d;
         sh_gain_q  <= sh_gain_d;
      end
   end

   // Shadow update, commit on a clean frame, rollback on a malformed frame.
   // The commit uses the shadow next-state so that a same-cycle final word is
   // included in the commit.
   always_comb begin
      sh_oper_d  = sh_oper_q;
      sh_ctrl_d  = sh_ctrl_q;
      sh_clamp_d = sh_clamp_q;
      sh_gain_d  = sh_gain_q;
      oper_d     = oper_q;
      ctrl_d     = ctrl_q;
      clamp_d    = clamp_q;
      gain_d     = gain_q;
      if (wr_stb_d) begin
         case (wr_addr_d)
            3'd0:    sh_oper_d  = wr_data_d[6:0];
            3'd1:    sh_ctrl_d  = wr_data_d[6:0];
            3'd2:    sh_clamp_d = wr_data_d[7:0];
            3'd3:    sh_gain_d  = wr_data_d[9:0];
            default: ;
         endcase
      end
      if (done_d) begin
         oper_d  = sh_oper_d;
         ctrl_d  = sh_ctrl_d;
         clamp_d = sh_clamp_d;
         gain_d  = sh_gain_d;
      end else if (err_d) begin
         sh_oper_d  = oper_q;
         sh_ctrl_d  = ctrl_q;
         sh_clamp_d = clamp_q;
         sh_gain_d  = gain_q;
      end
   end
`else
   // Direct update. Each completed word lands in its register in the same cycle
   // that wr_stb rises. Addresses 4..7 are strobed but do not change a register.
   always_comb begin
      oper_d  = oper_q;
      ctrl_d  = ctrl_q;
      clamp_d = clamp_q;
      gain_d  = gain_q;
      if (wr_stb_d) begin
         case (wr_addr_d)
            3'd0:    oper_d  = wr_data_d[6:0];
            3'd1:    ctrl_d  = wr_data_d[6:0];
            3'd2:    clamp_d = wr_data_d[7:0];
            3'd3:    gain_d  = wr_data_d[9:0];
            default: ;
         endcase
      end
   end
`endif

   // Visible AFE registers.
   always_ff @(posedge sys_clk or negedge rst_n) begin
      if (!rst_n) begin
         oper_q  <= '0;
         ctrl_q  <= '0;
         clamp_q <= CLAMP_RST;
         gain_q  <= '0;
      end else begin
         oper_q  <= oper_d;
         ctrl_q  <= ctrl_d;
         clamp_q <= clamp_d;
         gain_q  <= gain_d;
      end
   end

   assign oper       = oper_q;
   assign ctrl       = ctrl_q;
   assign clamp      = clamp_q;
   assign vga_gain   = gain_q;
   assign wr_stb     = wr_stb_q;
   assign wr_addr    = wr_addr_q;
   assign wr_data    = wr_data_q;
   assign frame_done = done_q;
   assign frame_err  = err_q;

endmodule

// File: tb/tb_ad9945_serial_rx.sv
// tb_ad9945_serial_rx
//   Directed bench for ad9945_serial_rx. It drives the pins with SCK at
//   sys_clk/4. The expected values are worked out by hand.
module tb_ad9945_serial_rx;

   logic        sys_clk = 1'b0;
   logic        rst_n   = 1'b0;
   logic        SL      = 1'b1;
   logic        SCK     = 1'b0;
   logic        SDATA   = 1'b0;
   logic [6:0]  oper;
   logic [6:0]  ctrl;
   logic [7:0]  clamp;
   logic [9:0]  vga_gain;
   logic        wr_stb;
   logic [2:0]  wr_addr;
   logic [11:0] wr_data;
   logic        frame_done;
   logic        frame_err;

   int checks = 0;
   int errors = 0;

   logic [2:0]  stb_addr[$];
   logic [11:0] stb_data[$];
   int done_cnt = 0;
   int err_cnt  = 0;

   logic [6:0] exp_oper;
   logic [6:0] exp_ctrl;
   logic [7:0] exp_clamp;
   logic [9:0] exp_gain;

   ad9945_serial_rx #(
      .SYNC_STAGES(2),
      .CLAMP_RST(8'd128)
   ) dut (
      .sys_clk(sys_clk),
      .rst_n(rst_n),
      .SL(SL),
      .SCK(SCK),
      .SDATA(SDATA),
      .oper(oper),
      .ctrl(ctrl),
      .clamp(clamp),
      .vga_gain(vga_gain),
      .wr_stb(wr_stb),
      .wr_addr(wr_addr),
      .wr_data(wr_data),
      .frame_done(frame_done),
      .frame_err(frame_err)
   );

   always #5 sys_clk = ~sys_clk;

   // Event recorder, sampled on the inactive clock edge
   always @(negedge sys_clk) begin
      if (wr_stb) begin
         stb_addr.push_back(wr_addr);
         stb_data.push_back(wr_data);
      end
      if (frame_done) done_cnt++;
      if (frame_err)  err_cnt++;
   end

   task automatic wait_neg(input int n);
      for (int i = 0; i < n; i++) @(negedge sys_clk);
   endtask

   task automatic send_bit(input logic b);
      SCK   = 1'b0;
      SDATA = b;
      wait_neg(2);
      SCK = 1'b1;
      wait_neg(2);
   endtask

   task automatic send_bits(input logic [11:0] v, input int n);
      for (int i = 0; i < n; i++) send_bit(v[i]);
   endtask

   task automatic sl_low();
      @(negedge sys_clk);
      SL = 1'b0;
      wait_neg(4);
   endtask

   task automatic sl_high();
      SCK = 1'b0;
      wait_neg(2);
      SL = 1'b1;
      wait_neg(10);
   endtask

   task automatic check_regs(input string tag);
      checks++;
      if (oper !== exp_oper) begin
         errors++; $display("FAIL %s oper got %h exp %h", tag, oper, exp_oper);
      end
      checks++;
      if (ctrl !== exp_ctrl) begin
         errors++; $display("FAIL %s ctrl got %h exp %h", tag, ctrl, exp_ctrl);
      end
      checks++;
      if (clamp !== exp_clamp) begin
         errors++; $display("FAIL %s clamp got %h exp %h", tag, clamp, exp_clamp);
      end
      checks++;
      if (vga_gain !== exp_gain) begin
         errors++; $display("FAIL %s vga_gain got %h exp %h", tag, vga_gain, exp_gain);
      end
   endtask

   task automatic test_reset();
      int b = stb_addr.size();
      rst_n = 1'b0;
      wait_neg(3);
      rst_n = 1'b1;
      wait_neg(10);
      exp_oper = 7'h00; exp_ctrl = 7'h00; exp_clamp = 8'd128; exp_gain = 10'h000;
      check_regs("reset");
      checks++;
      if (wr_addr !== 3'd0 || wr_data !== 12'h000) begin
         errors++; $display("FAIL reset_wr got %h/%h exp 0/000", wr_addr, wr_data);
      end
      checks++;
      if (stb_addr.size() != b || done_cnt != 0 || err_cnt != 0) begin
         errors++;
         $display("FAIL reset_strobes got stb=%0d done=%0d err=%0d exp 0/0/0",
                  stb_addr.size() - b, done_cnt, err_cnt);
      end
   endtask

   task automatic test_full_frame();
      logic [11:0] w[4] = '{12'h055, 12'h02A, 12'h040, 12'h3FF};
      int b = stb_addr.size();
      int d = done_cnt;
      int e = err_cnt;
      sl_low();
      send_bits(12'h000, 3);
      for (int i = 0; i < 4; i++) send_bits(w[i], 12);
      sl_high();
      exp_oper = 7'h55; exp_ctrl = 7'h2A; exp_clamp = 8'h40; exp_gain = 10'h3FF;
      check_regs("full");
      checks++;
      if (stb_addr.size() - b != 4) begin
         errors++; $display("FAIL full_stb_count got %0d exp 4", stb_addr.size() - b);
      end
      for (int i = 0; i < 4; i++) begin
         checks++;
         if (b + i >= stb_addr.size() || stb_addr[b+i] !== 3'(i) || stb_data[b+i] !== w[i]) begin
            errors++; $display("FAIL full_word%0d exp addr %0d data %h", i, i, w[i]);
         end
      end
      checks++;
      if (done_cnt - d != 1 || err_cnt - e != 0) begin
         errors++; $display("FAIL full_frame got done=%0d err=%0d exp 1/0", done_cnt - d, err_cnt - e);
      end
   endtask

   task automatic test_latency();
      logic [11:0] w = 12'h9A5;
      int d = done_cnt;
      sl_low();
      send_bits(12'h005, 3);          // addr 5: no register side effect
      send_bits(w, 11);
      SCK   = 1'b0;
      SDATA = w[11];
      wait_neg(2);
      SCK = 1'b1;                     // pin-level 12th rising edge
      for (int k = 1; k <= 5; k++) begin
         @(negedge sys_clk);
         checks++;
         if (wr_stb !== (k == 4)) begin
            errors++; $display("FAIL latency_stb_k%0d got %b exp %b", k, wr_stb, (k == 4));
         end
         if (k == 4) begin
            checks++;
            if (wr_addr !== 3'd5 || wr_data !== w) begin
               errors++; $display("FAIL latency_word got %0d/%h exp 5/%h", wr_addr, wr_data, w);
            end
         end
      end
      sl_high();
      check_regs("latency");
      checks++;
      if (done_cnt - d != 1) begin
         errors++; $display("FAIL latency_done got %0d exp 1", done_cnt - d);
      end
   endtask

   task automatic test_addr3();
      int b = stb_addr.size();
      int d = done_cnt;
      sl_low();
      send_bits(12'h003, 3);
      send_bits(12'h123, 12);
      send_bits(12'hFFF, 12);
      sl_high();
      exp_gain = 10'h123;
      check_regs("addr3");
      checks++;
      if (stb_addr.size() - b != 2 || stb_addr[b+1] !== 3'd4 || stb_data[b+1] !== 12'hFFF) begin
         errors++; $display("FAIL addr3_second_word exp 2 strobes, addr 4 data FFF, got %0d strobes",
                            stb_addr.size() - b);
      end
      checks++;
      if (done_cnt - d != 1) begin
         errors++; $display("FAIL addr3_done got %0d exp 1", done_cnt - d);
      end
   endtask

   task automatic test_partial_word();
      int b = stb_addr.size();
      int d = done_cnt;
      int e = err_cnt;
      sl_low();
      send_bits(12'h001, 3);
      send_bits(12'h07F, 12);
      send_bits(12'h015, 5);
      sl_high();
`ifndef AD9945_RX_SHADOW_EN
      exp_ctrl = 7'h7F;
`endif
      check_regs("partial");
      checks++;
      if (stb_addr.size() - b != 1 || stb_addr[b] !== 3'd1 || stb_data[b] !== 12'h07F) begin
         errors++; $display("FAIL partial_stb got %0d strobes exp 1 at addr 1 data 07F", stb_addr.size() - b);
      end
      checks++;
      if (err_cnt - e != 1 || done_cnt - d != 0) begin
         errors++; $display("FAIL partial_frame got err=%0d done=%0d exp 1/0", err_cnt - e, done_cnt - d);
      end
   endtask

   task automatic test_short_frames();
      int b = stb_addr.size();
      int d = done_cnt;
      int e = err_cnt;
      sl_low();
      send_bits(12'h002, 2);          // only 2 address bits
      sl_high();
      checks++;
      if (err_cnt - e != 1) begin
         errors++; $display("FAIL short_addr_err got %0d exp 1", err_cnt - e);
      end
      sl_low();
      send_bits(12'h002, 3);          // address only, no words
      sl_high();
      checks++;
      if (err_cnt - e != 2 || done_cnt - d != 0) begin
         errors++; $display("FAIL zero_word_err got err=%0d done=%0d exp 2/0", err_cnt - e, done_cnt - d);
      end
      checks++;
      if (stb_addr.size() != b) begin
         errors++; $display("FAIL short_stb got %0d exp 0", stb_addr.size() - b);
      end
      check_regs("short");
   endtask

   task automatic test_addr_wrap();
      int b = stb_addr.size();
      sl_low();
      send_bits(12'h007, 3);
      send_bits(12'hABC, 12);
      send_bits(12'hF66, 12);
      sl_high();
      exp_oper = 7'h66;
      check_regs("wrap");
      checks++;
      if (stb_addr.size() - b != 2 || stb_addr[b] !== 3'd7 || stb_addr[b+1] !== 3'd0) begin
         errors++; $display("FAIL wrap_addr got %0d strobes exp addr 7 then 0", stb_addr.size() - b);
      end
   endtask

   task automatic test_reset_midframe();
      int b;
      int d;
      int e;
      sl_low();
      send_bits(12'h000, 3);
      send_bits(12'h011, 12);
      send_bits(12'h01F, 5);
      @(negedge sys_clk);
      rst_n = 1'b0;
      wait_neg(3);
      rst_n = 1'b1;
      b = stb_addr.size();
      d = done_cnt;
      e = err_cnt;
      send_bits(12'h5A5, 12);         // SL still low: must be ignored
      send_bits(12'h0A5, 3);
      sl_high();
      exp_oper = 7'h00; exp_ctrl = 7'h00; exp_clamp = 8'd128; exp_gain = 10'h000;
      check_regs("rst_mid");
      checks++;
      if (stb_addr.size() != b || done_cnt != d || err_cnt != e) begin
         errors++; $display("FAIL rst_mid_quiet got stb=%0d done=%0d err=%0d exp 0/0/0",
                            stb_addr.size() - b, done_cnt - d, err_cnt - e);
      end
      sl_low();
      send_bits(12'h000, 3);
      send_bits(12'h011, 12);
      send_bits(12'h022, 12);
      send_bits(12'h033, 12);
      send_bits(12'h155, 12);
      sl_high();
      exp_oper = 7'h11; exp_ctrl = 7'h22; exp_clamp = 8'h33; exp_gain = 10'h155;
      check_regs("rst_next");
      checks++;
      if (stb_addr.size() - b != 4 || done_cnt - d != 1) begin
         errors++; $display("FAIL rst_next_frame got stb=%0d done=%0d exp 4/1", stb_addr.size() - b, done_cnt - d);
      end
   endtask

   initial begin
      test_reset();
      test_full_frame();
      test_latency();
      test_addr3();
      test_partial_word();
      test_short_frames();
      test_addr_wrap();
      test_reset_midframe();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
